// File: rtl/fcvt_sched.sv
// ============================================================================
//  Module   : fcvt_sched
//  Brief    : Round-robin scheduler sharing one FP-to-integer converter among
//             NREQ requesters, with tag pipeline and credit-protected FIFO.
//             Optional same-cycle result bypass: FCVT_BYPASS_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fcvt_sched #(
    parameter int NREQ  = 3,
    parameter int TAGW  = 9,
    parameter int LAT   = 1,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*82-1:0]        req_A,
    input  logic [NREQ*2-1:0]         req_fmt,
    input  logic [NREQ-1:0]           req_is32b,
    input  logic [NREQ*TAGW-1:0]      req_tag,
    output logic                      cvt_en,
    output logic                      cvt_clkEn,
    output logic [81:0]               cvt_A,
    output logic                      cvt_isSNG,
    output logic                      cvt_isDBL,
    output logic                      cvt_isEXT,
    output logic                      cvt_verbatim,
    output logic                      cvt_is32b,
    input  logic [63:0]               cvt_res,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [63:0]               out_res,
    output logic [TAGW-1:0]           out_tag,
    output logic [$clog2(NREQ)-1:0]   out_src
);

    localparam int SRCW = $clog2(NREQ);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int AW   = 82;

    logic                clken_q;
    logic [SRCW-1:0]     rr_q, rr_d;
    logic [CNTW-1:0]     credit_q, credit_d;
    logic [CNTW-1:0]     count_q, count_d;
    logic [PTRW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [AW-1:0]       a_q;

    logic [LAT-1:0]      pv_q;
    logic [TAGW-1:0]     ptag_q [LAT];
    logic [SRCW-1:0]     psrc_q [LAT];

    logic [63:0]         mres_q [DEPTH];
    logic [TAGW-1:0]     mtag_q [DEPTH];
    logic [SRCW-1:0]     msrc_q [DEPTH];

    logic                gnt_found;
    logic [SRCW-1:0]     gnt_idx;
    logic                issue_ok, issue_go;
    logic                fifo_ne, pop, push, byp_take, retire_v;
    logic [AW-1:0]       sel_A;
    logic [1:0]          sel_fmt;
    logic                sel_32;
    logic [TAGW-1:0]     sel_tag;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
    endfunction

    // Round-robin search starting at the pointer, wrapping modulo NREQ
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            logic [SRCW-1:0] idx;
            idx = (int'(rr_q) + k >= NREQ) ? SRCW'(int'(rr_q) + k - NREQ)
                                           : SRCW'(int'(rr_q) + k);
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    always_comb begin
        sel_A   = '0;
        sel_fmt = '0;
        sel_32  = 1'b0;
        sel_tag = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (gnt_idx == SRCW'(r)) begin
                sel_A   = req_A[r*AW +: AW];
                sel_fmt = req_fmt[r*2 +: 2];
                sel_32  = req_is32b[r];
                sel_tag = req_tag[r*TAGW +: TAGW];
            end
        end
    end

    assign retire_v = pv_q[LAT-1];
    assign fifo_ne  = (count_q != '0);

`ifdef FCVT_BYPASS_EN
    // A retiring result may leave directly when nothing older is queued
    assign out_valid = ~rst & (fifo_ne | retire_v);
    assign out_res   = fifo_ne ? mres_q[rd_q] : cvt_res;
    assign out_tag   = fifo_ne ? mtag_q[rd_q] : ptag_q[LAT-1];
    assign out_src   = fifo_ne ? msrc_q[rd_q] : psrc_q[LAT-1];
    assign byp_take  = ~rst & ~fifo_ne & retire_v & out_ready;
`else
    assign out_valid = ~rst & fifo_ne;
    assign out_res   = mres_q[rd_q];
    assign out_tag   = mtag_q[rd_q];
    assign out_src   = msrc_q[rd_q];
    assign byp_take  = 1'b0;
`endif

    assign pop  = ~rst & fifo_ne & out_ready;
    assign push = retire_v & ~byp_take;

    // A slot freed this cycle may be reused by this cycle's issue
    assign issue_ok = clken_q & ~rst & ((credit_q != '0) | pop | byp_take);
    assign issue_go = issue_ok & gnt_found;

    always_comb begin
        req_ready = '0;
        if (issue_go) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign cvt_en       = issue_go;
    assign cvt_clkEn    = clken_q & ~rst;
    assign cvt_A        = issue_go ? sel_A : a_q;
    assign cvt_is32b    = issue_go & sel_32;
    assign cvt_isSNG    = issue_go & (sel_fmt == 2'b00);
    assign cvt_isDBL    = issue_go & (sel_fmt == 2'b01);
    assign cvt_isEXT    = issue_go & (sel_fmt == 2'b10);
    assign cvt_verbatim = issue_go & (sel_fmt == 2'b11);

    always_comb begin
        rr_d     = rr_q;
        credit_d = credit_q;
        count_d  = count_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        if (issue_go) begin
            rr_d = (gnt_idx == SRCW'(NREQ - 1)) ? '0 : gnt_idx + SRCW'(1);
        end
        case ({issue_go, pop | byp_take})
            2'b10:   credit_d = credit_q - CNTW'(1);
            2'b01:   credit_d = credit_q + CNTW'(1);
            default: credit_d = credit_q;
        endcase
        case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
        if (push) begin
            wr_d = ptr_inc(wr_q);
        end
        if (pop) begin
            rd_d = ptr_inc(rd_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clken_q  <= 1'b0;
            rr_q     <= '0;
            credit_q <= CNTW'(DEPTH);
            count_q  <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            pv_q     <= '0;
            a_q      <= '0;
        end else begin
            clken_q  <= 1'b1;
            rr_q     <= rr_d;
            credit_q <= credit_d;
            count_q  <= count_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            a_q      <= cvt_A;
            pv_q[0]  <= issue_go;
            for (int s = 1; s < LAT; s++) begin
                pv_q[s] <= pv_q[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        ptag_q[0] <= sel_tag;
        psrc_q[0] <= gnt_idx;
        for (int s = 1; s < LAT; s++) begin
            ptag_q[s] <= ptag_q[s-1];
            psrc_q[s] <= psrc_q[s-1];
        end
        if (push) begin
            mres_q[wr_q] <= cvt_res;
            mtag_q[wr_q] <= ptag_q[LAT-1];
            msrc_q[wr_q] <= psrc_q[LAT-1];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fcvt_sched.sv
// ============================================================================
//  Module   : tb_fcvt_sched
//  Brief    : Self-checking bench for fcvt_sched with a queue-based reference
//             model and a converter stand-in. Honours FCVT_BYPASS_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fcvt_sched;

    localparam int NREQ  = 3;
    localparam int TAGW  = 9;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;
    localparam int SRCW  = 2;
`ifdef FCVT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*82-1:0]     req_A;
    logic [NREQ*2-1:0]      req_fmt;
    logic [NREQ-1:0]        req_is32b;
    logic [NREQ*TAGW-1:0]   req_tag;
    logic                   cvt_en, cvt_clkEn, cvt_isSNG, cvt_isDBL, cvt_isEXT;
    logic                   cvt_verbatim, cvt_is32b;
    logic [81:0]            cvt_A;
    logic [63:0]            cvt_res;
    logic                   out_valid, out_ready;
    logic [63:0]            out_res;
    logic [TAGW-1:0]        out_tag;
    logic [SRCW-1:0]        out_src;

    // Per-requester stimulus, packed onto the DUT ports
    logic [81:0]            tb_a   [NREQ];
    logic [1:0]             tb_f   [NREQ];
    logic                   tb_w   [NREQ];
    logic [TAGW-1:0]        tb_tag [NREQ];

    always_comb begin
        req_A = '0; req_fmt = '0; req_is32b = '0; req_tag = '0;
        for (int r = 0; r < NREQ; r++) begin
            req_A[r*82 +: 82]     = tb_a[r];
            req_fmt[r*2 +: 2]     = tb_f[r];
            req_is32b[r]          = tb_w[r];
            req_tag[r*TAGW +: TAGW] = tb_tag[r];
        end
    end

    always #5 clk = ~clk;

    fcvt_sched #(.NREQ(NREQ), .TAGW(TAGW), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_A(req_A),
        .req_fmt(req_fmt), .req_is32b(req_is32b), .req_tag(req_tag),
        .cvt_en(cvt_en), .cvt_clkEn(cvt_clkEn), .cvt_A(cvt_A),
        .cvt_isSNG(cvt_isSNG), .cvt_isDBL(cvt_isDBL), .cvt_isEXT(cvt_isEXT),
        .cvt_verbatim(cvt_verbatim), .cvt_is32b(cvt_is32b), .cvt_res(cvt_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_tag(out_tag), .out_src(out_src)
    );

    // Converter stand-in: A[63:0] is an IEEE double (verbatim passes it through)
    function automatic logic [63:0] conv(input logic [81:0] a, input logic verb, input logic is32);
        logic [63:0] v;
        real         r;
        longint      li;
        if (verb) begin
            v = a[63:0];
        end else begin
            r  = $bitstoreal(a[63:0]);
            li = longint'(r);
            v  = li;
        end
        if (is32) v[63:32] = 32'h0;
        return v;
    endfunction

    logic [63:0] cvt_pipe [LAT];
    always @(posedge clk) begin
        cvt_pipe[0] <= conv(cvt_A, cvt_verbatim, cvt_is32b);
        for (int i = 1; i < LAT; i++) cvt_pipe[i] <= cvt_pipe[i-1];
    end
    assign cvt_res = cvt_pipe[LAT-1];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [81:0] got, input logic [81:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model: queues of in-flight and queued results
    typedef struct {
        int              t;
        logic [TAGW-1:0] tag;
        int              src;
        logic [63:0]     res;
    } ent_t;

    ent_t infl[$];
    ent_t mfifo[$];
    int   cyc = 0;
    int   m_rr = 0;
    bit   prev_rst = 1'b1;

    always @(negedge clk) begin : model
        int          g, credits;
        bit          allowed, ret, e_ov, pop, byp;
        ent_t        head, rent;
        logic [NREQ-1:0] e_rdy;
        logic [3:0]  e_sel;
        cyc++;
        if (rst) begin
            chk("rst_req_ready", 82'(req_ready), 82'(0));
            chk("rst_cvt_en", 82'(cvt_en), 82'(0));
            chk("rst_clkEn", 82'(cvt_clkEn), 82'(0));
            chk("rst_out_valid", 82'(out_valid), 82'(0));
            chk("rst_selects", 82'({cvt_verbatim, cvt_isEXT, cvt_isDBL, cvt_isSNG}), 82'(0));
            infl.delete();
            mfifo.delete();
            m_rr     = 0;
            prev_rst = 1'b1;
        end else begin
            allowed = !prev_rst;
            ret     = (infl.size() > 0) && (infl[0].t + LAT == cyc);
            e_ov    = 1'b0;
            byp     = 1'b0;
            head    = '{0, '0, 0, '0};
            if (mfifo.size() > 0) begin
                e_ov = 1'b1;
                head = mfifo[0];
            end else if (BYP && ret) begin
                e_ov = 1'b1;
                head = infl[0];
                byp  = out_ready;
            end
            pop     = e_ov && out_ready;
            credits = DEPTH - mfifo.size() - infl.size();
            g = -1;
            if (allowed && (credits + (pop ? 1 : 0) >= 1)) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
                end
            end
            e_rdy = '0;
            e_sel = '0;
            if (g >= 0) begin
                e_rdy[g] = 1'b1;
                e_sel    = 4'(1 << tb_f[g]);
            end
            chk("req_ready", 82'(req_ready), 82'(e_rdy));
            chk("cvt_en", 82'(cvt_en), 82'(g >= 0));
            chk("cvt_clkEn", 82'(cvt_clkEn), 82'(allowed));
            chk("fmt_select", 82'({cvt_verbatim, cvt_isEXT, cvt_isDBL, cvt_isSNG}), 82'(e_sel));
            if (g >= 0) begin
                chk("cvt_A", cvt_A, tb_a[g]);
                chk("cvt_is32b", 82'(cvt_is32b), 82'(tb_w[g]));
            end
            chk("out_valid", 82'(out_valid), 82'(e_ov));
            if (e_ov) begin
                chk("out_res", 82'(out_res), 82'(head.res));
                chk("out_tag", 82'(out_tag), 82'(head.tag));
                chk("out_src", 82'(out_src), 82'(head.src));
            end
            if (pop && mfifo.size() > 0) void'(mfifo.pop_front());
            if (ret) begin
                rent = infl.pop_front();
                if (!byp) mfifo.push_back(rent);
            end
            if (g >= 0) begin
                infl.push_back('{cyc, tb_tag[g], g, conv(tb_a[g], tb_f[g] == 2'b11, tb_w[g])});
                m_rr = (g + 1) % NREQ;
            end
            prev_rst = 1'b0;
        end
    end

    // ---------------- stimulus
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int r, input logic [81:0] a, input logic [1:0] f,
                         input logic w, input logic [TAGW-1:0] tg);
        tb_a[r] = a; tb_f[r] = f; tb_w[r] = w; tb_tag[r] = tg;
        req_valid[r] = 1'b1;
    endtask

    task automatic issue_one(input int r, input logic [81:0] a, input logic [1:0] f,
                             input logic w, input logic [TAGW-1:0] tg);
        bit got;
        got = 1'b0;
        drive(r, a, f, w, tg);
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (req_ready[r]) got = 1'b1;
            step();
        end
        req_valid[r] = 1'b0;
        if (!got) begin
            tests++; fails++;
            $display("FAIL accept_timeout: req %0d not granted, required within 20 cycles", r);
        end
    endtask

    // Returns cycles from issue to out_valid; leaves time at that negedge
    task automatic wait_out(output int n);
        n = 0;
        for (int k = 1; k <= 20 && n == 0; k++) begin
            @(negedge clk);
            if (out_valid) n = k;
        end
        if (n == 0) begin
            tests++; fails++;
            $display("FAIL out_timeout: out_valid absent, required within 20 cycles");
        end
    endtask

    localparam logic [63:0] D_2   = 64'h4000000000000000;
    localparam logic [63:0] D_3   = 64'h4008000000000000;
    localparam logic [63:0] D_5   = 64'h4014000000000000;
    localparam logic [63:0] D_7   = 64'h401C000000000000;
    localparam logic [63:0] D_100 = 64'h4059000000000000;
    localparam logic [63:0] D_M1  = 64'hBFF0000000000000;
    localparam logic [17:0] UPPER = 18'h2A5A5;

    logic [63:0] va [6];
    logic [1:0]  vf [6];
    logic        vw [6];
    logic [63:0] ve [6];

    initial begin
        int n, acc, g, exp_g;
        rst = 1'b1; out_ready = 1'b1; req_valid = '0;
        for (int r = 0; r < NREQ; r++) begin
            tb_a[r] = '0; tb_f[r] = '0; tb_w[r] = 1'b0; tb_tag[r] = '0;
        end
        va[0] = D_M1;                  vf[0] = 2'b00; vw[0] = 1'b1; ve[0] = 64'h00000000FFFFFFFF;
        va[1] = D_M1;                  vf[1] = 2'b00; vw[1] = 1'b0; ve[1] = 64'hFFFFFFFFFFFFFFFF;
        va[2] = D_100;                 vf[2] = 2'b10; vw[2] = 1'b0; ve[2] = 64'd100;
        va[3] = 64'h0123456789ABCDEF;  vf[3] = 2'b11; vw[3] = 1'b0; ve[3] = 64'h0123456789ABCDEF;
        va[4] = 64'h0123456789ABCDEF;  vf[4] = 2'b11; vw[4] = 1'b1; ve[4] = 64'h0000000089ABCDEF;
        va[5] = D_7;                   vf[5] = 2'b01; vw[5] = 1'b1; ve[5] = 64'd7;
        repeat (3) step();

        // single request from requester 1 right at reset release
        rst = 1'b0;
        drive(1, {UPPER, D_3}, 2'b01, 1'b0, 9'h005);
        @(negedge clk);
        chk("first_cycle_ready", 82'(req_ready), 82'(0));
        chk("first_cycle_clkEn", 82'(cvt_clkEn), 82'(0));
        step();
        @(negedge clk);
        chk("t1_ready", 82'(req_ready), 82'(3'b010));
        chk("t1_isDBL", 82'(cvt_isDBL), 82'(1));
        step();
        req_valid[1] = 1'b0;
        wait_out(n);
        chk("t1_latency", 82'(n), 82'(BYP ? 1 : 2));
        chk("t1_res", 82'(out_res), 82'(64'd3));
        chk("t1_tag", 82'(out_tag), 82'(9'h005));
        chk("t1_src", 82'(out_src), 82'(1));
        step();
        repeat (3) step();

        // all requesters streaming: strict rotation, pointer resumes after 1
        drive(0, {UPPER, D_2}, 2'b01, 1'b0, 9'h010);
        drive(1, {UPPER, D_5}, 2'b00, 1'b1, 9'h011);
        drive(2, {UPPER, D_7}, 2'b10, 1'b0, 9'h012);
        exp_g = 2;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("rr_grant", 82'(req_ready), 82'(1 << exp_g));
            exp_g = (exp_g + 1) % NREQ;
            step();
            for (int r = 0; r < NREQ; r++) tb_tag[r] = tb_tag[r] + 9'h020;
        end
        req_valid = '0;
        repeat (5) step();

        // backpressure: credits limit acceptance to DEPTH
        out_ready = 1'b0;
        drive(0, {UPPER, D_5}, 2'b01, 1'b0, 9'h030);
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (req_ready[0]) acc++;
            step();
            tb_tag[0] = tb_tag[0] + 9'h001;
        end
        chk("bp_accepts", 82'(acc), 82'(DEPTH));
        out_ready = 1'b1;
        @(negedge clk);
        chk("resume_on_pop", 82'(req_ready), 82'(3'b001));
        chk("resume_out_valid", 82'(out_valid), 82'(1));
        step();
        repeat (5) step();
        req_valid = '0;
        repeat (8) step();

        // format / width vectors through requester 2
        for (int i = 0; i < 6; i++) begin
            issue_one(2, {UPPER, va[i]}, vf[i], vw[i], 9'(9'h040 + i));
            wait_out(n);
            chk("vec_res", 82'(out_res), 82'(ve[i]));
            chk("vec_src", 82'(out_src), 82'(2));
            step();
            repeat (2) step();
        end

        // reset with 2 queued and 1 in flight
        out_ready = 1'b0;
        drive(0, {UPPER, D_2}, 2'b01, 1'b0, 9'h050);
        acc = 0;
        for (int i = 0; i < 20 && acc < 3; i++) begin
            @(negedge clk);
            if (req_ready[0]) acc++;
            step();
        end
        req_valid[0] = 1'b0;
        chk("pre_rst_accepts", 82'(acc), 82'(3));
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_stale", 82'(out_valid), 82'(0));
            step();
        end
        out_ready = 1'b0;
        drive(0, {UPPER, D_7}, 2'b01, 1'b0, 9'h060);
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready[0]) acc++;
            step();
        end
        chk("credits_after_rst", 82'(acc), 82'(DEPTH));
        req_valid = '0;
        out_ready = 1'b1;
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
